// File: rtl/prgrom_access_scheduler_if.sv
// rtl/prgrom_access_scheduler_if.sv - fetch, UART loader and program memory signals of the access scheduler
interface prgrom_access_scheduler_if #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32
);
  logic                  iLoadRequest;
  logic                  iUartWordValid;
  logic [DATA_WIDTH-1:0] iUartWordData;
  logic                  iUartDone;
  logic                  oUartWordReady;
  logic [ADDR_WIDTH-1:0] iFetchAddr;
  logic [DATA_WIDTH-1:0] oFetchInstruction;
  logic [DATA_WIDTH-1:0] iRomReadData;
  logic [ADDR_WIDTH-1:0] oRomAddr;
  logic [DATA_WIDTH-1:0] oRomWriteData;
  logic                  oRomWriteEnable;
  logic                  oCpuHold;
  logic [ADDR_WIDTH:0]   oLoadedWords;
  logic [1:0]            oMode;

  modport slave (
    input  iLoadRequest, iUartWordValid, iUartWordData, iUartDone,
           iFetchAddr, iRomReadData,
    output oUartWordReady, oFetchInstruction, oRomAddr, oRomWriteData,
           oRomWriteEnable, oCpuHold, oLoadedWords, oMode
  );

  modport master (
    output iLoadRequest, iUartWordValid, iUartWordData, iUartDone,
           iFetchAddr, iRomReadData,
    input  oUartWordReady, oFetchInstruction, oRomAddr, oRomWriteData,
           oRomWriteEnable, oCpuHold, oLoadedWords, oMode
  );
endinterface

// File: rtl/prgrom_access_scheduler.sv
// rtl/prgrom_access_scheduler.sv - time-shares program memory between CPU fetch and the UART program loader
module prgrom_access_scheduler #(
  parameter int ADDR_WIDTH     = 14,
  parameter int DATA_WIDTH     = 32,
  parameter int RELEASE_CYCLES = 4
) (
  input logic                      iCpuClock,
  input logic                      iCpuReset,
  prgrom_access_scheduler_if.slave bus
);
  localparam logic [1:0] MODE_RUN     = 2'd0;
  localparam logic [1:0] MODE_DRAIN   = 2'd1;
  localparam logic [1:0] MODE_LOAD    = 2'd2;
  localparam logic [1:0] MODE_RELEASE = 2'd3;

  localparam int              REL_W    = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;
  localparam logic [REL_W-1:0] REL_LAST = REL_W'(RELEASE_CYCLES - 1);

  logic [1:0]            mode;
  logic [ADDR_WIDTH:0]   wrPtr;
  logic [ADDR_WIDTH-1:0] wrAddr;
  logic [DATA_WIDTH-1:0] wrData;
  logic                  wrPending;
  logic                  doneLatched;
  logic [REL_W-1:0]      relCount;
  logic                  memFull;
  logic                  wordReady;
  logic                  handshake;
  logic                  loadEnd;

  // The extra pointer bit marks a completely filled memory, so the pointer never wraps.
  assign memFull   = wrPtr[ADDR_WIDTH];
  assign wordReady = (mode == MODE_LOAD) && !wrPending && !memFull;
  assign handshake = wordReady && bus.iUartWordValid;
  // Loading ends on a cycle that accepts nothing new; a strobe active now completes at this edge.
  assign loadEnd   = !handshake && (doneLatched || bus.iUartDone || memFull);

  // Mode sequencing, release countdown and remembering a done flag that arrived with a word.
  always_ff @(posedge iCpuClock or posedge iCpuReset) begin
    if (iCpuReset) begin
      mode        <= MODE_RUN;
      relCount    <= '0;
      doneLatched <= 1'b0;
    end else begin
      case (mode)
        MODE_RUN: begin
          if (bus.iLoadRequest) mode <= MODE_DRAIN;
        end
        MODE_DRAIN: begin
          doneLatched <= 1'b0;
          mode        <= MODE_LOAD;
        end
        MODE_LOAD: begin
          if (handshake && bus.iUartDone) doneLatched <= 1'b1;
          if (loadEnd) begin
            mode     <= MODE_RELEASE;
            relCount <= '0;
          end
        end
        default: begin
          if (relCount != REL_LAST) relCount <= relCount + 1'b1;
          else if (!bus.iLoadRequest) mode <= MODE_RUN;
        end
      endcase
    end
  end

  // Write pointer and the one-cycle delayed write strobe capturing each accepted word.
  always_ff @(posedge iCpuClock or posedge iCpuReset) begin
    if (iCpuReset) begin
      wrPtr     <= '0;
      wrAddr    <= '0;
      wrData    <= '0;
      wrPending <= 1'b0;
    end else begin
      wrPending <= handshake;
      if (mode == MODE_DRAIN) begin
        wrPtr <= '0;
      end else if (handshake) begin
        wrPtr  <= wrPtr + (ADDR_WIDTH+1)'(1);
        wrAddr <= wrPtr[ADDR_WIDTH-1:0];
        wrData <= bus.iUartWordData;
      end
    end
  end

  assign bus.oRomAddr          = (mode == MODE_RUN) ? bus.iFetchAddr :
                                 wrPending          ? wrAddr         : wrPtr[ADDR_WIDTH-1:0];
  assign bus.oFetchInstruction = (mode == MODE_RUN) ? bus.iRomReadData : '0;
  assign bus.oRomWriteData     = wrData;
  assign bus.oRomWriteEnable   = wrPending;
  assign bus.oUartWordReady    = wordReady;
  assign bus.oCpuHold          = (mode != MODE_RUN);
  assign bus.oLoadedWords      = wrPtr;
  assign bus.oMode             = mode;
endmodule

// File: doc/prgrom_access_scheduler.md
Name: prgrom_access_scheduler

Overview:
- Time-shares the single-port program ROM/RAM between CPU instruction fetch and the UART program loader.
- In RUN mode, fetch addresses pass straight through to the memory.
- In load mode, the CPU is held, UART-assembled words are written sequentially from address 0, and the CPU is released after a fixed drain period.
- Sits between the instruction fetcher, the UART word assembler and the program memory in the CPU top level.

Parameters:
ADDR_WIDTH, 14, word-address width of program memory; capacity is 2^ADDR_WIDTH words
DATA_WIDTH, 32, instruction word width
RELEASE_CYCLES, 4, cycles oCpuHold stays asserted after loading ends; must be >= 1

Ports:
iCpuClock  input  1  CPU clock; all state updates on posedge
iCpuReset  input  1  reset, asynchronous, active-high
iLoadRequest  input  1  level request to enter load mode (board switch, pre-synchronised)
iUartWordValid  input  1  a complete word is available from the UART assembler
iUartWordData  input  DATA_WIDTH  word to write
iUartDone  input  1  loader reports end of transfer
oUartWordReady  output  1  scheduler accepts a word this cycle
iFetchAddr  input  ADDR_WIDTH  fetch word address from the instruction fetcher
oFetchInstruction  output  DATA_WIDTH  instruction returned to the fetcher
iRomReadData  input  DATA_WIDTH  memory read data
oRomAddr  output  ADDR_WIDTH  memory address
oRomWriteData  output  DATA_WIDTH  memory write data
oRomWriteEnable  output  1  memory write strobe
oCpuHold  output  1  holds the CPU (ORed into CPU reset by the top level)
oLoadedWords  output  ADDR_WIDTH+1  number of words written in the last or current load
oMode  output  2  state: 0 RUN, 1 DRAIN, 2 LOAD, 3 RELEASE

Behaviour:
Reset (asynchronous, iCpuReset=1):
- State RUN.
- oCpuHold=0, oRomWriteEnable=0, oRomWriteData=0.
- Write pointer=0, oLoadedWords=0, release counter=0.
- Takes effect immediately even mid-load; a pending write is dropped.

RUN:
- oRomAddr=iFetchAddr and oFetchInstruction=iRomReadData, both combinational.
- oRomWriteEnable=0, oUartWordReady=0, oCpuHold=0.
- iLoadRequest=1 at posedge -> DRAIN.

DRAIN (exactly 1 cycle):
- oCpuHold=1.
- Write pointer and oLoadedWords cleared to 0.
- Next state LOAD.

LOAD:
- oCpuHold=1.
- oUartWordReady=1 when no write is pending and pointer < 2^ADDR_WIDTH.
- Handshake: iUartWordValid & oUartWordReady at posedge k.
- Cycle k+1: oRomWriteEnable=1, oRomAddr=pointer value at edge k, oRomWriteData=word, oUartWordReady=0.
- Pointer and oLoadedWords increment at edge k.
- Write strobe lasts exactly 1 cycle; maximum throughput is one word per 2 cycles.
- Non-write cycles: oRomAddr=pointer, oRomWriteEnable=0.
- Exit to RELEASE on either condition, but only after any pending write has completed:
  - iUartDone=1;
  - pointer reaches 2^ADDR_WIDTH (memory full; no wrap, further words never accepted).
- iUartDone together with a handshake: the word is written and counted, then RELEASE.
- iLoadRequest deasserting in LOAD is ignored; only iUartDone or full ends loading.

RELEASE:
- oCpuHold=1, oUartWordReady=0, no writes.
- Counter runs RELEASE_CYCLES cycles.
- Then -> RUN only when iLoadRequest=0; otherwise wait in RELEASE. This prevents an immediate reload.
- oLoadedWords holds its value until the next DRAIN or reset.

oFetchInstruction:
- 0x0000_0000 (nop) in every state except RUN.
- The fetcher samples on negedge; data is valid because oRomAddr is stable from posedge.

Test Plan:
1. RUN passthrough: iFetchAddr=0x0005, iRomReadData=0x2008_0001 -> oRomAddr=0x0005, oFetchInstruction=0x2008_0001, oRomWriteEnable=0, oCpuHold=0, oMode=0.
2. Three-word load: assert iLoadRequest -> one cycle oMode=1, then oMode=2. Send words 0x1111_1111, 0x2222_2222, 0x3333_3333 back-to-back -> one-cycle writes at addr 0, 1, 2, oUartWordReady low in each write cycle. Then iUartDone=1 -> oMode=3 for 4 cycles; drop iLoadRequest -> oMode=0, oCpuHold=0, oLoadedWords=3.
3. Full memory, ADDR_WIDTH=2: send 5 words -> 4 written at addr 0..3, 5th never accepted (ready 0), auto RELEASE, oLoadedWords=4.
4. Simultaneous iUartWordValid and iUartDone on the first word 0xDEAD_BEEF -> write at addr 0 occurs, then RELEASE, oLoadedWords=1.
5. iLoadRequest held high through RELEASE -> oMode stays 3 and oCpuHold=1 beyond 4 cycles; drop request -> RUN next cycle.
6. Reset mid-LOAD after 2 words with a write pending -> immediately oMode=0, oRomWriteEnable=0, oCpuHold=0, oLoadedWords=0.
